// File: rtl/vga_pixel_row_writer.sv
// vga_pixel_row_writer
//   Avalon-MM slave that accepts 16-bit pixel words from the Nios, buffers them
//   in a small FIFO and streams them to the VGA pixel pipeline over valid/ready.
//   STATUS/CONTROL registers share the slave; readdata is registered (1 cycle).
module vga_pixel_row_writer #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WATER  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LOW_WATER_C = CNT_W'(LOW_WATER);

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_STATUS  = 2'd1,
      REG_CONTROL = 2'd2,
      REG_RSVD    = 2'd3
   } reg_addr_e;

   // FIFO storage and registered state
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              enable_q, enable_d;
   logic              irq_en_q, irq_en_d;
   logic [DATA_W-1:0] last_wr_q, last_wr_d;
   logic [31:0]       readdata_q, readdata_d;
   logic              irq_q, irq_d;

   // Decoded bus and handshake events
   logic      bus_wr;
   reg_addr_e reg_sel;
   logic      empty;
   logic      full;
   logic      pop;
   logic      push_req;
   logic      push_ok;
   logic      push_drop;
   logic      flush;
   logic      ovf_clr;
   logic      ctrl_wr;
   logic [31:0] status_word;

   // Bits of writedata outside the fields decoded below are intentionally ignored.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   assign reg_sel   = reg_addr_e'(address);
   assign bus_wr    = chipselect & ~write_n;
   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_CNT);
   assign pix_valid = enable_q & ~empty;
   assign pix_data  = mem_q[rd_ptr_q];
   assign pop       = pix_valid & pix_ready;

   assign push_req  = bus_wr & (reg_sel == REG_DATA);
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign push_ok   = push_req & (~full | pop);
   assign push_drop = push_req & full & ~pop;
   assign ctrl_wr   = bus_wr & (reg_sel == REG_CONTROL);
   assign flush     = ctrl_wr & writedata[1];
   assign ovf_clr   = bus_wr & (reg_sel == REG_STATUS) & writedata[2];

   assign readdata  = readdata_q;
   assign irq       = irq_q;

   // Next-state logic for pointers, count, flags and the read mux
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      enable_d    = enable_q;
      irq_en_d    = irq_en_q;
      last_wr_d   = last_wr_q;
      status_word = '0;
      readdata_d  = '0;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      // A drop in the same cycle as a clear leaves overflow set.
      if (push_drop)    overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;

      if (ctrl_wr) begin
         enable_d = writedata[0];
         irq_en_d = writedata[2];
      end

      if (push_ok) last_wr_d = writedata[DATA_W-1:0];

      irq_d = irq_en_q & (count_d <= LOW_WATER_C);

      status_word[0]            = empty;
      status_word[1]            = full;
      status_word[2]            = overflow_q;
      status_word[8 +: CNT_W]   = count_q;

      case (reg_sel)
         REG_DATA:    readdata_d = 32'(last_wr_q);
         REG_STATUS:  readdata_d = status_word;
         REG_CONTROL: readdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
         default:     readdata_d = '0;
      endcase
   end

   // FIFO storage write
   // NOTE: the data array has no reset; validity is tracked by count/pointers alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
   end

   // State register with asynchronous active-low reset
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         last_wr_q  <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
         irq_en_q   <= irq_en_d;
         last_wr_q  <= last_wr_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: tb/tb_vga_pixel_row_writer.sv
// Testbench for vga_pixel_row_writer: directed scenarios followed by a random
// phase, every cycle compared against a queue-based behavioural model.
module tb_vga_pixel_row_writer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 16;
   localparam int LW     = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [1:0]        address = 2'd0;
   logic              chipselect = 1'b0;
   logic              write_n = 1'b1;
   logic [31:0]       writedata = 32'd0;
   logic [31:0]       readdata;
   logic              irq;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready = 1'b0;

   vga_pixel_row_writer #(
      .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .LOW_WATER(LW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
   );

   always #5 clk = ~clk;

   int    n_cmp  = 0;
   int    n_fail = 0;
   string phase  = "init";

   // Behavioural model state
   logic [DATA_W-1:0] q_m[$];
   logic              ovf_m, en_m, ien_m, irq_m;
   logic [DATA_W-1:0] last_m;
   logic [31:0]       rd_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_m.delete();
      ovf_m  = 1'b0;
      en_m   = 1'b0;
      ien_m  = 1'b0;
      irq_m  = 1'b0;
      last_m = '0;
      rd_m   = '0;
   endtask

   function automatic logic [31:0] reg_value(input logic [1:0] a);
      int sz;
      sz = q_m.size();
      case (a)
         2'd0: return 32'(last_m);
         2'd1: return (32'(sz) << 8) | (32'(ovf_m) << 2)
                      | (32'(sz == DEPTH) << 1) | 32'(sz == 0);
         2'd2: return (32'(ien_m) << 2) | 32'(en_m);
         default: return 32'd0;
      endcase
   endfunction

   // Advance one clock: update the model from the inputs now applied, then compare.
   task automatic cycle();
      logic wr, pop, ovf_set, ien_old;
      logic [31:0] rnext;
      wr      = chipselect && !write_n;
      pop     = en_m && (q_m.size() > 0) && pix_ready;
      rnext   = reg_value(address);
      ien_old = ien_m;
      ovf_set = 1'b0;

      if (wr && address == 2'd2 && writedata[1]) q_m.delete();
      else if (pop) void'(q_m.pop_front());

      if (wr && address == 2'd0) begin
         if (q_m.size() < DEPTH) begin
            q_m.push_back(writedata[DATA_W-1:0]);
            last_m = writedata[DATA_W-1:0];
         end else begin
            ovf_m   = 1'b1;
            ovf_set = 1'b1;
         end
      end
      if (wr && address == 2'd1 && writedata[2] && !ovf_set) ovf_m = 1'b0;
      if (wr && address == 2'd2) begin
         en_m  = writedata[0];
         ien_m = writedata[2];
      end
      irq_m = ien_old && (q_m.size() <= LW);
      rd_m  = rnext;

      @(posedge clk);
      #1;
      check("pix_valid", 32'(pix_valid), 32'(en_m && q_m.size() > 0));
      check("irq", 32'(irq), 32'(irq_m));
      check("readdata", readdata, rd_m);
      if (en_m && q_m.size() > 0) check("pix_data", 32'(pix_data), 32'(q_m[0]));
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      cycle();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a);
      address = a;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      model_reset();

      // Reset state, then read every register address
      phase = "reset";
      #12;
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_readdata", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) bus_read(2'(a));
      bus_read(2'd0);

      // Two words streamed with pix_ready high
      phase = "stream";
      bus_write(2'd2, 32'h1);
      pix_ready = 1'b1;
      bus_write(2'd0, 32'h1234);
      bus_write(2'd0, 32'hABCD);
      idle(2);

      // Fill past capacity with pix_ready low
      phase = "fill";
      pix_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) bus_write(2'd0, 32'(i));
      bus_read(2'd1);
      bus_read(2'd0);
      bus_read(2'd0);

      // Clear overflow, then push into a full FIFO while a word leaves
      phase = "full_push_pop";
      bus_write(2'd1, 32'h4);
      bus_read(2'd1);
      pix_ready = 1'b1;
      bus_write(2'd0, 32'h55AA);
      bus_read(2'd1);
      idle(DEPTH + 2);

      // Low-water interrupt during drain, then flush
      phase = "irq";
      pix_ready = 1'b0;
      bus_write(2'd2, 32'h5);
      for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h100 + 32'(i));
      pix_ready = 1'b1;
      idle(5);
      pix_ready = 1'b0;
      bus_read(2'd1);
      bus_write(2'd2, 32'h7);
      bus_read(2'd1);
      bus_read(2'd2);

      // Mid-stream asynchronous reset
      phase = "mid_reset";
      bus_write(2'd2, 32'h1);
      for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h200 + 32'(i));
      #3;
      reset_n = 1'b0;
      #1;
      check("async_pix_valid", 32'(pix_valid), 32'd0);
      check("async_irq", 32'(irq), 32'd0);
      model_reset();
      #2;
      reset_n = 1'b1;
      bus_read(2'd1);
      bus_read(2'd1);

      // Random bus traffic and back-pressure
      phase = "random";
      bus_write(2'd2, 32'h5);
      for (int i = 0; i < 600; i++) begin
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 2) == 0);
         address    = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
         writedata  = $urandom;
         if (address == 2'd2) writedata[0] = ($urandom_range(0, 7) != 0);
         if (address == 2'd2) writedata[1] = ($urandom_range(0, 3) == 0);
         pix_ready  = 1'($urandom_range(0, 2) == 0);
         cycle();
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
